countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 85 ++++++++
 tb/tb_countdown_timer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Countdown timer with one-shot and auto-reload modes.
// A load of a non-zero value starts a count that decrements by one per enabled
// edge. When the count goes from 1 to 0 the block pulses done for one cycle.
// It then either reloads the last loaded value and keeps running, or stops in
// EXPIRED. Every output comes straight from a register or from the state decode.
module countdown_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             enable,
   input  logic             reload_en,
   output logic [WIDTH-1:0] counter,
   output logic             done,
   output logic             busy,
   output logic             expired
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_done;

   state_t           w_nextState;
   logic [WIDTH-1:0] w_nextCount;
   logic [WIDTH-1:0] w_nextReload;
   logic             w_nextDone;

   // State, count, reload value and done pulse registers; reset aborts any count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_count  <= ZERO;
         r_reload <= ZERO;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_count  <= w_nextCount;
         r_reload <= w_nextReload;
         r_done   <= w_nextDone;
      end
   end

   // Next-state logic: load wins over everything, then terminal count, then decrement
   always_comb begin
      w_nextState  = r_state;
      w_nextCount  = r_count;
      w_nextReload = r_reload;
      w_nextDone   = 1'b0;
      if (load) begin
         w_nextCount  = data;
         w_nextReload = data;
         w_nextState  = (data != ZERO) ? RUN : IDLE;
      end else if (r_state == RUN && enable) begin
         if (r_count == ONE) begin
            w_nextDone = 1'b1;
            if (reload_en) begin
               w_nextCount = r_reload;
            end else begin
               w_nextCount = ZERO;
               w_nextState = EXPIRED;
            end
         end else if (r_count != ZERO) begin
            w_nextCount = r_count - ONE;
         end
      end
   end

   assign counter = r_count;
   assign done    = r_done;
   assign busy    = (r_state == RUN);
   assign expired = (r_state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer.
// The driver applies one set of inputs per cycle. A reference model predicts the
// outputs after the next edge and queues that prediction. The monitor pops one
// prediction after each rising edge and compares it with the DUT.
module tb_countdown_timer;

   localparam int WIDTH = 4;

   typedef struct {
      int unsigned count;
      bit          done;
      bit          busy;
      bit          expired;
   } expect_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] data = '0;
   logic             enable = 1'b0;
   logic             reload_en = 1'b0;
   logic [WIDTH-1:0] counter;
   logic             done;
   logic             busy;
   logic             expired;

   int compared = 0;
   int mismatched = 0;

   expect_t expQ[$];

   // Model state: remaining ticks, the value a reload restores, and the mode
   int unsigned mRemaining = 0;
   int unsigned mReloadVal = 0;
   bit          mRunning = 0;
   bit          mExpired = 0;

   countdown_timer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .data      (data),
      .enable    (enable),
      .reload_en (reload_en),
      .counter   (counter),
      .done      (done),
      .busy      (busy),
      .expired   (expired)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int unsigned act, input int unsigned req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the predicted result
   task automatic applyStimulus(input bit ld, input int unsigned d, input bit en, input bit rel);
      expect_t e;
      @(negedge clk);
      load      = ld;
      data      = WIDTH'(d);
      enable    = en;
      reload_en = rel;
      e.done = 0;
      if (ld) begin
         mRemaining = d;
         mReloadVal = d;
         mRunning   = (d > 0);
         mExpired   = 0;
      end else if (mRunning && en) begin
         if (mRemaining == 1) begin
            e.done = 1;
            if (rel) begin
               mRemaining = mReloadVal;
            end else begin
               mRemaining = 0;
               mRunning   = 0;
               mExpired   = 1;
            end
         end else begin
            mRemaining = mRemaining - 1;
         end
      end
      e.count   = mRemaining;
      e.busy    = mRunning;
      e.expired = mExpired;
      expQ.push_back(e);
   endtask

   // Monitor: one prediction per rising edge, compared shortly after the edge
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("counter", counter, e.count);
            checkOutput("done", done, e.done);
            checkOutput("busy", busy, e.busy);
            checkOutput("expired", expired, e.expired);
         end
      end
   end

   // Reset asserted between edges must clear everything at once
   task automatic midRunReset();
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_reset_counter", counter, 0);
      checkOutput("async_reset_busy", busy, 0);
      checkOutput("async_reset_done", done, 0);
      mRemaining = 0;
      mReloadVal = 0;
      mRunning   = 0;
      mExpired   = 0;
      @(posedge clk);
      #2;
      checkOutput("reset_hold_counter", counter, 0);
      reset = 1'b1;
   endtask

   initial begin
      int edges;
      bit seen;
      bit rel;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_counter", counter, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_expired", expired, 0);
      @(negedge clk);
      reset = 1'b1;

      // Stays idle after reset until a load, whatever enable does
      repeat (3) applyStimulus(0, 0, 1, 1);

      // One-shot count of 11 with an explicit check on when done arrives
      applyStimulus(1, 11, 1, 0);
      edges = 0;
      seen  = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         applyStimulus(0, 0, 1, 0);
         @(posedge clk);
         #2;
         if (done) begin
            edges = i;
            seen  = 1;
         end
      end
      checkOutput("oneshot_latency", edges, 11);
      repeat (3) applyStimulus(0, 0, 1, 1);

      // Auto-reload of 7 over three periods
      applyStimulus(1, 7, 1, 1);
      repeat (22) applyStimulus(0, 0, 1, 1);

      // Pause at 3 for three cycles, then resume
      applyStimulus(1, 5, 1, 0);
      repeat (2) applyStimulus(0, 0, 1, 0);
      repeat (3) applyStimulus(0, 0, 0, 0);
      repeat (4) applyStimulus(0, 0, 1, 0);

      // Load on the terminal-count cycle wins and no done appears
      applyStimulus(1, 3, 1, 0);
      repeat (2) applyStimulus(0, 0, 1, 0);
      applyStimulus(1, 4, 1, 0);
      repeat (2) applyStimulus(0, 0, 1, 0);

      // Zero load from RUN goes back to idle
      applyStimulus(1, 0, 1, 1);
      repeat (2) applyStimulus(0, 0, 1, 1);

      // Reset while counting at 6
      applyStimulus(1, 8, 1, 0);
      repeat (2) applyStimulus(0, 0, 1, 0);
      midRunReset();
      repeat (3) applyStimulus(0, 0, 1, 1);

      // Random traffic, including all-ones loads and reload_en changes mid-count
      rel = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) rel = ~rel;
         applyStimulus(($urandom_range(0, 11) == 0), $urandom_range(0, (1 << WIDTH) - 1),
                       ($urandom_range(0, 3) != 0), rel);
      end

      @(negedge clk);
      load   = 1'b0;
      enable = 1'b0;
      @(posedge clk);
      #3;
      checkOutput("queue_drained", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
